// File: rtl/decoder_seq_if.sv
// Control and output bundle for decoder_seq.
// The master side drives the controls; the slave side, the decoder, drives back out/idx/wrap.
interface decoder_seq_if #(
    parameter int SEL_W = 3
) ();
    localparam int OUT_W = 2 ** SEL_W;

    logic             en;
    logic [1:0]       mode;
    logic [SEL_W-1:0] sel;
    logic             load;
    logic             dir;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] idx;
    logic             wrap;

    modport master (
        output en, mode, sel, load, dir,
        input  out, idx, wrap
    );

    modport slave (
        input  en, mode, sel, load, dir,
        output out, idx, wrap
    );
endinterface

// File: rtl/decoder_seq.sv
// Registered binary-to-one-hot decoder for LED banks and row/column select lines.
// Modes: 00 decode, 01 latch on load, 10 auto-scan at a prescaled rate, 11 blank.
// out is always the one-hot of idx, optionally inverted, except in blank mode.
//
// mode   | meaning
// DECODE | idx follows sel on every enabled edge
// LATCH  | idx captures sel when load is high
// SCAN   | idx steps up/down once every PRESCALE enabled edges; load reseeds it
// BLANK  | idx held, every output bit inactive
module decoder_seq #(
    parameter int SEL_W      = 3,
    parameter int PRESCALE   = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_seq_if.slave  bus
);
    localparam int OUT_W = 2 ** SEL_W;
    localparam int PS_W  = $clog2(PRESCALE) + 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] IDX_MAX  = {SEL_W{1'b1}};
    localparam logic [OUT_W-1:0] OUT_IDLE = {OUT_W{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_DECODE = 2'b00,
        MODE_LATCH  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_BLANK  = 2'b11
    } mode_t;

    mode_t            mode_in;
    logic [SEL_W-1:0] idx_q, idx_n;
    logic [PS_W-1:0]  psc_q, psc_n;
    logic [OUT_W-1:0] out_q, out_n;
    logic             wrap_q, wrap_n;

    assign mode_in  = mode_t'(bus.mode);
    assign bus.out  = out_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;

    // Next index, prescaler, wrap and output pattern for the coming enabled edge.
    always_comb begin
        idx_n  = idx_q;
        psc_n  = '0;
        wrap_n = 1'b0;
        out_n  = OUT_IDLE;

        unique case (mode_in)
            MODE_DECODE: idx_n = bus.sel;
            MODE_LATCH: begin
                if (bus.load) begin
                    idx_n = bus.sel;
                end
            end
            MODE_SCAN: begin
                if (bus.load) begin
                    idx_n = bus.sel;
                end else if (psc_q == PS_LAST) begin
                    if (bus.dir) begin
                        idx_n  = idx_q - SEL_W'(1);
                        wrap_n = (idx_q == '0);
                    end else begin
                        idx_n  = idx_q + SEL_W'(1);
                        wrap_n = (idx_q == IDX_MAX);
                    end
                end else begin
                    psc_n = psc_q + PS_W'(1);
                end
            end
            MODE_BLANK: idx_n = idx_q;
            default:    idx_n = idx_q;
        endcase

        // Polarity is folded in here so the register already holds the pin level.
        if (mode_in != MODE_BLANK) begin
            out_n = (OUT_W'(1) << idx_n) ^ OUT_IDLE;
        end
    end

    // State register: everything freezes when en is low, except wrap which drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            psc_q  <= '0;
            out_q  <= OUT_IDLE;
            wrap_q <= 1'b0;
        end else if (bus.en) begin
            idx_q  <= idx_n;
            psc_q  <= psc_n;
            out_q  <= out_n;
            wrap_q <= wrap_n;
        end else begin
            wrap_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: an active-high and an active-low instance share the same stimulus.
// A behavioural model tracks index, scan progress, wrap and blanking for comparison.
module tb_decoder_seq;
    localparam int SEL_W    = 3;
    localparam int OUT_W    = 2 ** SEL_W;
    localparam int PRESCALE = 4;
    localparam logic [63:0] MASK = (64'd1 << OUT_W) - 64'd1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    decoder_seq_if #(.SEL_W(SEL_W)) bus0 ();
    decoder_seq_if #(.SEL_W(SEL_W)) bus1 ();

    decoder_seq #(.SEL_W(SEL_W), .PRESCALE(PRESCALE), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    decoder_seq #(.SEL_W(SEL_W), .PRESCALE(PRESCALE), .ACTIVE_LOW(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_idx   = 0;
    int m_edges = 0;
    bit m_wrap  = 1'b0;
    bit m_blank = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_out_hi();
        return m_blank ? 64'd0 : (64'd1 << m_idx);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".out"},    64'(bus0.out),  exp_out_hi());
        check({tag, ".out_al"}, 64'(bus1.out),  ~exp_out_hi() & MASK);
        check({tag, ".idx"},    64'(bus0.idx),  64'(m_idx));
        check({tag, ".wrap"},   64'(bus0.wrap), 64'(m_wrap));
        check({tag, ".idx_al"}, 64'(bus1.idx),  64'(m_idx));
    endtask

    task automatic model_reset();
        m_idx   = 0;
        m_edges = 0;
        m_wrap  = 1'b0;
        m_blank = 1'b1;
    endtask

    // m_edges counts enabled scan edges since the last seed; a step lands every PRESCALE of them.
    task automatic model_edge(input bit e, input int md, input int s, input bit ld, input bit d);
        m_wrap = 1'b0;
        if (e) begin
            m_blank = (md == 3);
            case (md)
                0: begin m_idx = s; m_edges = 0; end
                1: begin if (ld) m_idx = s; m_edges = 0; end
                2: begin
                    if (ld) begin
                        m_idx   = s;
                        m_edges = 0;
                    end else begin
                        m_edges++;
                        if (m_edges == PRESCALE) begin
                            m_edges = 0;
                            if (d) begin
                                m_wrap = (m_idx == 0);
                                m_idx  = (m_idx + OUT_W - 1) % OUT_W;
                            end else begin
                                m_wrap = (m_idx == OUT_W - 1);
                                m_idx  = (m_idx + 1) % OUT_W;
                            end
                        end
                    end
                end
                default: m_edges = 0;
            endcase
        end
    endtask

    task automatic step(input string tag, input bit e, input int md, input int s,
                        input bit ld, input bit d);
        bus0.en = e;  bus0.mode = 2'(md); bus0.sel = SEL_W'(s); bus0.load = ld; bus0.dir = d;
        bus1.en = e;  bus1.mode = 2'(md); bus1.sel = SEL_W'(s); bus1.load = ld; bus1.dir = d;
        @(posedge clk);
        model_edge(e, md, s, ld, d);
        #1;
        check_all(tag);
    endtask

    initial begin
        bus0.en = 1'b0; bus0.mode = 2'b00; bus0.sel = '0; bus0.load = 1'b0; bus0.dir = 1'b0;
        bus1.en = 1'b0; bus1.mode = 2'b00; bus1.sel = '0; bus1.load = 1'b0; bus1.dir = 1'b0;

        // reset state
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        check("reset.out_lit",    64'(bus0.out), 64'h00);
        check("reset.out_al_lit", 64'(bus1.out), 64'hFF);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // decode, one clock latency
        step("dec5", 1, 0, 5, 0, 0);
        check("dec5.lit", 64'(bus0.out), 64'h20);
        for (int i = 0; i < OUT_W; i++) step("dec_sweep", 1, 0, i, 0, 0);
        step("dec2", 1, 0, 2, 0, 0);
        check("dec2.al_lit", 64'(bus1.out), 64'hFB);

        // blank holds idx
        step("blank", 1, 3, 7, 0, 0);
        check("blank.al_lit", 64'(bus1.out), 64'hFF);
        check("blank.idx_lit", 64'(bus0.idx), 64'd2);
        step("unblank", 1, 0, 2, 0, 0);

        // latch and enable
        step("lat_ld3", 1, 1, 3, 1, 0);
        check("lat_ld3.lit", 64'(bus0.out), 64'h08);
        step("lat_hold", 1, 1, 6, 0, 0);
        step("en_off", 0, 1, 1, 1, 0);
        check("en_off.lit", 64'(bus0.out), 64'h08);
        step("lat_ld1", 1, 1, 1, 1, 0);
        check("lat_ld1.lit", 64'(bus0.out), 64'h02);

        // scan up with wrap
        step("scan_ld6", 1, 2, 6, 1, 0);
        for (int i = 0; i < 8; i++) step("scan_up", 1, 2, 0, 0, 0);
        check("scan_up.wrap_lit", 64'(bus0.wrap), 64'd1);
        check("scan_up.out_lit",  64'(bus0.out),  64'h01);
        for (int i = 0; i < 4; i++) step("scan_up2", 1, 2, 0, 0, 0);
        check("scan_up2.out_lit", 64'(bus0.out), 64'h02);

        // scan down, then flip direction mid-interval
        step("scan_ld1", 1, 2, 1, 1, 1);
        for (int i = 0; i < 8; i++) step("scan_dn", 1, 2, 0, 0, 1);
        check("scan_dn.out_lit", 64'(bus0.out), 64'h80);
        step("scan_dn_a", 1, 2, 0, 0, 1);
        step("scan_dn_b", 1, 2, 0, 0, 1);
        step("flip_a", 1, 2, 0, 0, 0);
        step("flip_b", 1, 2, 0, 0, 0);
        check("flip.wrap_lit", 64'(bus0.wrap), 64'd1);

        // en low in the middle of a scan freezes the prescaler and drops wrap
        step("scan_freeze", 0, 2, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("scan_resume", 1, 2, 0, 0, 0);

        // async reset mid-scan
        step("rs_ld4", 1, 2, 4, 1, 0);
        step("rs_p1", 1, 2, 0, 0, 0);
        step("rs_p2", 1, 2, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst", 1, 2, 0, 0, 0);
        check("post_rst.idx_lit", 64'(bus0.idx), 64'd0);
        step("post_rst_step", 1, 2, 0, 0, 0);
        check("post_rst_step.idx_lit", 64'(bus0.idx), 64'd1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int  md;
            bit  e, ld, d;
            int  s;
            e  = ($urandom_range(0, 7) != 0);
            md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 2;
            ld = ($urandom_range(0, 9) == 0);
            d  = ($urandom_range(0, 15) == 0) ? ~bus0.dir : bus0.dir;
            s  = int'($urandom_range(0, OUT_W - 1));
            step("rand", e, md, s, ld, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
